// File: rtl/display_saida_pkg.sv
// Shared types and constants for the decimal 7-segment display path.
// Segment patterns are active-high {g,f,e,d,c,b,a}; polarity is applied at the outputs.
package display_saida_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StLatch
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;

  localparam logic [6:0] SEG_D0 = 7'h3F;
  localparam logic [6:0] SEG_D1 = 7'h06;
  localparam logic [6:0] SEG_D2 = 7'h5B;
  localparam logic [6:0] SEG_D3 = 7'h4F;
  localparam logic [6:0] SEG_D4 = 7'h66;
  localparam logic [6:0] SEG_D5 = 7'h6D;
  localparam logic [6:0] SEG_D6 = 7'h7D;
  localparam logic [6:0] SEG_D7 = 7'h07;
  localparam logic [6:0] SEG_D8 = 7'h7F;
  localparam logic [6:0] SEG_D9 = 7'h6F;

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] seg;
    seg = SEG_BLANK;
    unique case (digit)
      4'd0: seg = SEG_D0;
      4'd1: seg = SEG_D1;
      4'd2: seg = SEG_D2;
      4'd3: seg = SEG_D3;
      4'd4: seg = SEG_D4;
      4'd5: seg = SEG_D5;
      4'd6: seg = SEG_D6;
      4'd7: seg = SEG_D7;
      4'd8: seg = SEG_D8;
      4'd9: seg = SEG_D9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/display_saida_if.sv
// Value-in / segments-out bundle between the output register and the HEX display driver.
interface display_saida_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] valor_in;
  logic             signed_mode;
  logic [6:0]       hex_sinal;
  logic [6:0]       hex_centena;
  logic [6:0]       hex_dezena;
  logic [6:0]       hex_unidade;
  logic             busy;
  logic             done;

  modport master (
    output valor_in, signed_mode,
    input  hex_sinal, hex_centena, hex_dezena, hex_unidade, busy, done
  );

  modport slave (
    input  valor_in, signed_mode,
    output hex_sinal, hex_centena, hex_dezena, hex_unidade, busy, done
  );
endinterface

// File: rtl/display_saida_bcd_to_7seg.sv
// Combinational BCD digit to 7-segment decoder with blanking and selectable polarity.
module display_saida_bcd_to_7seg
  import display_saida_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       active_low,
  output logic [6:0] seg
);
  logic [6:0] seg_ah;

  always_comb begin
    seg_ah = blank ? SEG_BLANK : seg_encode(digit);
    seg    = active_low ? ~seg_ah : seg_ah;
  end
endmodule

// File: rtl/display_saida.sv
// Sequential double-dabble conversion of the SAP output value to sign/hundreds/tens/units
// 7-segment digits; outputs only change in the LATCH state so they never glitch.
module display_saida
  import display_saida_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          BLANK_LEADING  = 1'b1
) (
  input logic            clock,
  input logic            clear,
  display_saida_if.slave bus
);
  localparam int              CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [6:0]      SegOff  = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

  state_e           state_q, state_d;
  logic [WIDTH:0]   snap_q, snap_d;
  logic             snap_valid_q, snap_valid_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [11:0]      bcd_q, bcd_d, bcd_adj;
  logic [CntW-1:0]  count_q, count_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [6:0]       hex_sinal_q, hex_sinal_d;
  logic [6:0]       hex_centena_q, hex_centena_d;
  logic [6:0]       hex_dezena_q, hex_dezena_d;
  logic [6:0]       hex_unidade_q, hex_unidade_d;

  logic [WIDTH:0] snap_in;
  logic           neg_in;
  logic           blank_c, blank_d;
  logic [6:0]     seg_c, seg_d, seg_u, sign_ah;

  assign snap_in = {bus.signed_mode, bus.valor_in};
  assign neg_in  = bus.signed_mode & bus.valor_in[WIDTH-1];

  // Leading-zero blanking works on the finished BCD held during LATCH.
  assign blank_c = BLANK_LEADING && (bcd_q[11:8] == 4'd0);
  assign blank_d = BLANK_LEADING && (bcd_q[11:4] == 8'd0);
  assign sign_ah = neg_q ? SEG_MINUS : SEG_BLANK;

  display_saida_bcd_to_7seg u_seg_centena (
    .digit      (bcd_q[11:8]),
    .blank      (blank_c),
    .active_low (SEG_ACTIVE_LOW),
    .seg        (seg_c)
  );

  display_saida_bcd_to_7seg u_seg_dezena (
    .digit      (bcd_q[7:4]),
    .blank      (blank_d),
    .active_low (SEG_ACTIVE_LOW),
    .seg        (seg_d)
  );

  display_saida_bcd_to_7seg u_seg_unidade (
    .digit      (bcd_q[3:0]),
    .blank      (1'b0),
    .active_low (SEG_ACTIVE_LOW),
    .seg        (seg_u)
  );

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    snap_d        = snap_q;
    snap_valid_d  = snap_valid_q;
    mag_d         = mag_q;
    bcd_d         = bcd_q;
    count_d       = count_q;
    neg_d         = neg_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    hex_sinal_d   = hex_sinal_q;
    hex_centena_d = hex_centena_q;
    hex_dezena_d  = hex_dezena_q;
    hex_unidade_d = hex_unidade_q;

    unique case (state_q)
      StIdle: begin
        if (!snap_valid_q || (snap_in != snap_q)) begin
          snap_d       = snap_in;
          snap_valid_d = 1'b1;
          busy_d       = 1'b1;
          neg_d        = neg_in;
          mag_d        = neg_in ? (~bus.valor_in + WIDTH'(1)) : bus.valor_in;
          bcd_d        = '0;
          count_d      = '0;
          state_d      = StShift;
        end
      end
      StShift: begin
        {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
        count_d        = count_q + CntW'(1);
        if (count_q == CntLast) begin
          state_d = StLatch;
        end
      end
      StLatch: begin
        hex_sinal_d   = SEG_ACTIVE_LOW ? ~sign_ah : sign_ah;
        hex_centena_d = seg_c;
        hex_dezena_d  = seg_d;
        hex_unidade_d = seg_u;
        done_d        = 1'b1;
        busy_d        = 1'b0;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q       <= StIdle;
      snap_q        <= '0;
      snap_valid_q  <= 1'b0;
      mag_q         <= '0;
      bcd_q         <= '0;
      count_q       <= '0;
      neg_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      hex_sinal_q   <= SegOff;
      hex_centena_q <= SegOff;
      hex_dezena_q  <= SegOff;
      hex_unidade_q <= SegOff;
    end else begin
      state_q       <= state_d;
      snap_q        <= snap_d;
      snap_valid_q  <= snap_valid_d;
      mag_q         <= mag_d;
      bcd_q         <= bcd_d;
      count_q       <= count_d;
      neg_q         <= neg_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      hex_sinal_q   <= hex_sinal_d;
      hex_centena_q <= hex_centena_d;
      hex_dezena_q  <= hex_dezena_d;
      hex_unidade_q <= hex_unidade_d;
    end
  end

  assign bus.hex_sinal   = hex_sinal_q;
  assign bus.hex_centena = hex_centena_q;
  assign bus.hex_dezena  = hex_dezena_q;
  assign bus.hex_unidade = hex_unidade_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_display_saida.sv
// Directed bench for display_saida: dut_a blanks leading zeros, dut_b always shows 3 digits.
module tb_display_saida;
  localparam logic [6:0] S0 = 7'h40;
  localparam logic [6:0] S1 = 7'h79;
  localparam logic [6:0] S2 = 7'h24;
  localparam logic [6:0] S5 = 7'h12;
  localparam logic [6:0] S7 = 7'h78;
  localparam logic [6:0] S8 = 7'h00;
  localparam logic [6:0] S9 = 7'h10;
  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] MI = 7'h3F;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] valor = 8'd0;
  logic       sm = 1'b0;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  display_saida_if #(.WIDTH(8)) ifa ();
  display_saida_if #(.WIDTH(8)) ifb ();

  assign ifa.valor_in    = valor;
  assign ifa.signed_mode = sm;
  assign ifb.valor_in    = valor;
  assign ifb.signed_mode = sm;

  display_saida #(.WIDTH(8), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)) dut_a (
    .clock (clk),
    .clear (clear),
    .bus   (ifa)
  );

  display_saida #(.WIDTH(8), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)) dut_b (
    .clock (clk),
    .clear (clear),
    .bus   (ifb)
  );

  // Apply a value at a falling edge and return the cycle index at which done is seen (-1 = none).
  task automatic run_conv(input logic [7:0] v, input logic s, output int lat);
    lat = -1;
    @(negedge clk);
    valor = v;
    sm    = s;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (ifa.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade} !== {4{BL}}) begin
      failures++;
      $display("FAIL rst_hex got=%h exp=%h",
               {ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade}, {4{BL}});
    end
    checks++;
    if ({ifa.busy, ifa.done, ifb.busy, ifb.done} !== 4'b0000) begin
      failures++;
      $display("FAIL rst_flags got=%b exp=0000", {ifa.busy, ifa.done, ifb.busy, ifb.done});
    end
  endtask

  task automatic test_first_conversion;
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at = -1;
    @(negedge clk);
    clear = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      #1;
      if (ifa.busy) busy_cnt++;
      if (ifa.done) begin
        done_cnt++;
        done_at = i;
      end
    end
    checks++;
    if (busy_cnt != 9) begin
      failures++;
      $display("FAIL first_busy_cycles got=%0d exp=9", busy_cnt);
    end
    checks++;
    if (done_cnt != 1 || done_at != 10) begin
      failures++;
      $display("FAIL first_done got=%0d@%0d exp=1@10", done_cnt, done_at);
    end
    checks++;
    if ({ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade} !==
        {BL, BL, BL, S0}) begin
      failures++;
      $display("FAIL first_hex_a got=%h exp=%h",
               {ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade},
               {BL, BL, BL, S0});
    end
    checks++;
    if ({ifb.hex_sinal, ifb.hex_centena, ifb.hex_dezena, ifb.hex_unidade} !==
        {BL, S0, S0, S0}) begin
      failures++;
      $display("FAIL first_hex_b got=%h exp=%h",
               {ifb.hex_sinal, ifb.hex_centena, ifb.hex_dezena, ifb.hex_unidade},
               {BL, S0, S0, S0});
    end
  endtask

  task automatic test_unsigned;
    int lat;
    run_conv(8'd255, 1'b0, lat);
    checks++;
    if (lat != 10) begin
      failures++;
      $display("FAIL u255_latency got=%0d exp=10", lat);
    end
    checks++;
    if ({ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade} !==
        {BL, S2, S5, S5}) begin
      failures++;
      $display("FAIL u255_hex got=%h exp=%h",
               {ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade},
               {BL, S2, S5, S5});
    end
    // Same bits, now signed: 8'hFF reads as -1.
    run_conv(8'hFF, 1'b1, lat);
    checks++;
    if (lat != 10) begin
      failures++;
      $display("FAIL sFF_latency got=%0d exp=10", lat);
    end
    checks++;
    if ({ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade} !==
        {MI, BL, BL, S1}) begin
      failures++;
      $display("FAIL sFF_hex got=%h exp=%h",
               {ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade},
               {MI, BL, BL, S1});
    end
  endtask

  task automatic test_signed;
    int lat;
    run_conv(8'h80, 1'b1, lat);
    checks++;
    if (lat != 10 ||
        {ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade} !==
        {MI, S1, S2, S8}) begin
      failures++;
      $display("FAIL s80_hex got=%h lat=%0d exp=%h lat=10",
               {ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade}, lat,
               {MI, S1, S2, S8});
    end
    run_conv(8'h7F, 1'b1, lat);
    checks++;
    if (lat != 10 ||
        {ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade} !==
        {BL, S1, S2, S7}) begin
      failures++;
      $display("FAIL s7F_hex got=%h lat=%0d exp=%h lat=10",
               {ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade}, lat,
               {BL, S1, S2, S7});
    end
  endtask

  task automatic test_blanking;
    int lat;
    run_conv(8'd7, 1'b0, lat);
    checks++;
    if (lat != 10 ||
        {ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade} !==
        {BL, BL, BL, S7}) begin
      failures++;
      $display("FAIL u7_hex_a got=%h lat=%0d exp=%h lat=10",
               {ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade}, lat,
               {BL, BL, BL, S7});
    end
    checks++;
    if ({ifb.hex_sinal, ifb.hex_centena, ifb.hex_dezena, ifb.hex_unidade} !==
        {BL, S0, S0, S7}) begin
      failures++;
      $display("FAIL u7_hex_b got=%h exp=%h",
               {ifb.hex_sinal, ifb.hex_centena, ifb.hex_dezena, ifb.hex_unidade},
               {BL, S0, S0, S7});
    end
    run_conv(8'd105, 1'b0, lat);
    checks++;
    if (lat != 10 ||
        {ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade} !==
        {BL, S1, S0, S5}) begin
      failures++;
      $display("FAIL u105_hex got=%h lat=%0d exp=%h lat=10",
               {ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade}, lat,
               {BL, S1, S0, S5});
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int bcnt = 0;
    int done_cnt = 0;
    int low_cnt = 0;
    int glitches = 0;
    int d1 = -1;
    int d2 = -1;
    run_conv(8'd7, 1'b0, lat);
    checks++;
    if (lat != 10) begin
      failures++;
      $display("FAIL b2b_pre_latency got=%0d exp=10", lat);
    end
    @(negedge clk);
    valor = 8'd200;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      if (ifa.busy) bcnt++;
      if (i < 20 && !ifa.busy) low_cnt++;
      if (i < 10 && ifa.hex_unidade !== S7) glitches++;
      if (ifa.done) begin
        done_cnt++;
        if (d1 < 0) begin
          d1 = i;
          checks++;
          if ({ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade} !==
              {BL, S2, S0, S0}) begin
            failures++;
            $display("FAIL b2b_first_hex got=%h exp=%h",
                     {ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade},
                     {BL, S2, S0, S0});
          end
        end else begin
          d2 = i;
        end
      end
      if (ifa.busy && bcnt == 3) begin
        @(negedge clk);
        valor = 8'd201;
      end
    end
    checks++;
    if (glitches != 0) begin
      failures++;
      $display("FAIL b2b_hold got=%0d glitches exp=0", glitches);
    end
    checks++;
    if (done_cnt != 2 || d1 != 10 || d2 != 20) begin
      failures++;
      $display("FAIL b2b_done got=%0d@%0d,%0d exp=2@10,20", done_cnt, d1, d2);
    end
    checks++;
    if (low_cnt != 1) begin
      failures++;
      $display("FAIL b2b_busy_gap got=%0d exp=1", low_cnt);
    end
    checks++;
    if ({ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade} !==
        {BL, S2, S0, S1}) begin
      failures++;
      $display("FAIL b2b_second_hex got=%h exp=%h",
               {ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade},
               {BL, S2, S0, S1});
    end
  endtask

  task automatic test_reset_mid;
    int lat = -1;
    @(negedge clk);
    valor = 8'd99;
    repeat (4) @(posedge clk);
    #3;
    clear = 1'b0;
    #1;
    checks++;
    if ({ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade, ifa.busy} !==
        {{4{BL}}, 1'b0}) begin
      failures++;
      $display("FAIL mid_rst_async got=%h exp=%h",
               {ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade, ifa.busy},
               {{4{BL}}, 1'b0});
    end
    @(negedge clk);
    clear = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (ifa.done) begin
        lat = i;
        break;
      end
    end
    checks++;
    if (lat != 10) begin
      failures++;
      $display("FAIL mid_rst_latency got=%0d exp=10", lat);
    end
    checks++;
    if ({ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade} !==
        {BL, BL, S9, S9}) begin
      failures++;
      $display("FAIL mid_rst_hex_a got=%h exp=%h",
               {ifa.hex_sinal, ifa.hex_centena, ifa.hex_dezena, ifa.hex_unidade},
               {BL, BL, S9, S9});
    end
    checks++;
    if ({ifb.hex_sinal, ifb.hex_centena, ifb.hex_dezena, ifb.hex_unidade} !==
        {BL, S0, S9, S9}) begin
      failures++;
      $display("FAIL mid_rst_hex_b got=%h exp=%h",
               {ifb.hex_sinal, ifb.hex_centena, ifb.hex_dezena, ifb.hex_unidade},
               {BL, S0, S9, S9});
    end
  endtask

  initial begin
    test_reset;
    test_first_conversion;
    test_unsigned;
    test_signed;
    test_blanking;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
